// File: rtl/aqua_pkg.sv
// Shared types for the commit buffer: the regfile writeback package and
// the per-entry record held in the buffer.
package aqua_pkg;

    localparam int COMMIT_DEPTH = 8;
    localparam int XLEN         = 32;
    localparam int REG_W        = 5;

    typedef struct packed {
        logic             wren_instr1;
        logic [REG_W-1:0] rd_addr_instr1;
        logic [XLEN-1:0]  rd_data_instr1;
        logic             wren_instr2;
        logic [REG_W-1:0] rd_addr_instr2;
        logic [XLEN-1:0]  rd_data_instr2;
    } writeback_s;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] rd;
        logic             wren;
        logic [XLEN-1:0]  data;
    } commit_entry_s;

endpackage

// File: rtl/wb_commit_ptr.sv
// Head/tail/occupancy bookkeeping for the commit buffer, including the
// allocation-ready and empty flags derived from the registered count.
module wb_commit_ptr
    import aqua_pkg::*;
#(
    parameter int DEPTH = COMMIT_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [1:0]       i_alloc_cnt,
    input  logic [1:0]       i_retire_cnt,
    output logic [TAG_W-1:0] o_head,
    output logic [TAG_W-1:0] o_tail,
    output logic             o_alloc_rdy,
    output logic             o_empty
);

    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] ALLOC_LIMIT = CNT_W'(DEPTH - 2);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q + TAG_W'(i_retire_cnt);
        tail_d  = tail_q + TAG_W'(i_alloc_cnt);
        count_d = count_q + CNT_W'(i_alloc_cnt) - CNT_W'(i_retire_cnt);
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_head      = head_q;
    assign o_tail      = tail_q;
    assign o_alloc_rdy = (count_q <= ALLOC_LIMIT);
    assign o_empty     = (count_q == '0);

endmodule

// File: rtl/wb_commit_buffer.sv
// Dual-issue in-order commit buffer: allocates in program order, accepts
// out-of-order completions by tag, retires up to two head entries per cycle.
module wb_commit_buffer
    import aqua_pkg::*;
#(
    parameter int DEPTH = COMMIT_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_alloc_vld1,
    input  logic             i_alloc_vld2,
    input  logic [4:0]       i_alloc_rd1,
    input  logic [4:0]       i_alloc_rd2,
    input  logic             i_alloc_wren1,
    input  logic             i_alloc_wren2,
    output logic             o_alloc_rdy,
    output logic [TAG_W-1:0] o_alloc_tag1,
    output logic [TAG_W-1:0] o_alloc_tag2,
    input  logic             i_cmp_vld1,
    input  logic [TAG_W-1:0] i_cmp_tag1,
    input  logic [31:0]      i_cmp_data1,
    input  logic             i_cmp_vld2,
    input  logic [TAG_W-1:0] i_cmp_tag2,
    input  logic [31:0]      i_cmp_data2,
    output writeback_s       o_wb_rf_pkg,
    output logic             o_empty
);

    commit_entry_s    entries_q [DEPTH];
    commit_entry_s    entries_d [DEPTH];
    writeback_s       wb_q, wb_d;
    logic [TAG_W-1:0] head, head_nxt, tail;
    commit_entry_s    head_e, next_e;
    logic             alloc_rdy, acc1, acc2, ret1, ret2;
    logic [1:0]       alloc_cnt, retire_cnt;

    wb_commit_ptr #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_ptr (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_alloc_cnt  (alloc_cnt),
        .i_retire_cnt (retire_cnt),
        .o_head       (head),
        .o_tail       (tail),
        .o_alloc_rdy  (alloc_rdy),
        .o_empty      (o_empty)
    );

    assign head_nxt   = head + TAG_W'(1);
    assign head_e     = entries_q[head];
    assign next_e     = entries_q[head_nxt];
    assign ret1       = head_e.valid & head_e.done;
    assign ret2       = ret1 & next_e.valid & next_e.done;
    assign acc1       = i_alloc_vld1 & alloc_rdy;
    assign acc2       = i_alloc_vld2 & alloc_rdy;
    assign alloc_cnt  = 2'(acc1) + 2'(acc2);
    assign retire_cnt = 2'(ret1) + 2'(ret2);

    // A lone younger request is compacted into the tail slot.
    assign o_alloc_tag1 = tail;
    assign o_alloc_tag2 = (i_alloc_vld2 & ~i_alloc_vld1) ? tail : tail + TAG_W'(1);
    assign o_alloc_rdy  = alloc_rdy;

    // Retire clears after completion so a stray late completion cannot revive a retired slot.
    always_comb begin
        entries_d = entries_q;
        if (i_cmp_vld1 && entries_q[i_cmp_tag1].valid) begin
            entries_d[i_cmp_tag1].done = 1'b1;
            entries_d[i_cmp_tag1].data = i_cmp_data1;
        end
        if (i_cmp_vld2 && entries_q[i_cmp_tag2].valid) begin
            entries_d[i_cmp_tag2].done = 1'b1;
            entries_d[i_cmp_tag2].data = i_cmp_data2;
        end
        if (ret1) entries_d[head]     = '0;
        if (ret2) entries_d[head_nxt] = '0;
        if (acc1) entries_d[tail] = '{valid: 1'b1, done: 1'b0, rd: i_alloc_rd1,
                                      wren: i_alloc_wren1, data: '0};
        if (acc2) entries_d[o_alloc_tag2] = '{valid: 1'b1, done: 1'b0, rd: i_alloc_rd2,
                                              wren: i_alloc_wren2, data: '0};
        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
        end
    end

    // The younger of two same-register writes wins, so the older write is dropped.
    always_comb begin
        wb_d = '0;
        if (ret1) begin
            wb_d.rd_addr_instr1 = head_e.rd;
            wb_d.rd_data_instr1 = head_e.data;
            wb_d.wren_instr1    = head_e.wren & (head_e.rd != '0);
        end
        if (ret2) begin
            wb_d.rd_addr_instr2 = next_e.rd;
            wb_d.rd_data_instr2 = next_e.data;
            wb_d.wren_instr2    = next_e.wren & (next_e.rd != '0);
        end
        if (wb_d.wren_instr1 && wb_d.wren_instr2 &&
            (wb_d.rd_addr_instr1 == wb_d.rd_addr_instr2)) begin
            wb_d.wren_instr1 = 1'b0;
        end
        if (i_flush) wb_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            wb_q <= '0;
        end else begin
            entries_q <= entries_d;
            wb_q      <= wb_d;
        end
    end

    assign o_wb_rf_pkg = wb_q;

    a_cmp1_live: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_cmp_vld1 |-> entries_q[i_cmp_tag1].valid)
        else $warning("wb_commit_buffer: completion on port 1 to idle entry ignored");
    a_cmp2_live: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_cmp_vld2 |-> entries_q[i_cmp_tag2].valid)
        else $warning("wb_commit_buffer: completion on port 2 to idle entry ignored");
    a_cmp_distinct: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_cmp_vld1 && i_cmp_vld2 && (i_cmp_tag1 == i_cmp_tag2)));

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Self-checking bench for wb_commit_buffer: directed vector table, corner
// sequences (full, flush, async reset) and random traffic against a queue model.
module tb_wb_commit_buffer;
    import aqua_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_alloc_vld1 = 1'b0, i_alloc_vld2 = 1'b0;
    logic [4:0]       i_alloc_rd1 = '0, i_alloc_rd2 = '0;
    logic             i_alloc_wren1 = 1'b0, i_alloc_wren2 = 1'b0;
    logic             o_alloc_rdy;
    logic [TAG_W-1:0] o_alloc_tag1, o_alloc_tag2;
    logic             i_cmp_vld1 = 1'b0, i_cmp_vld2 = 1'b0;
    logic [TAG_W-1:0] i_cmp_tag1 = '0, i_cmp_tag2 = '0;
    logic [31:0]      i_cmp_data1 = '0, i_cmp_data2 = '0;
    writeback_s       o_wb_rf_pkg;
    logic             o_empty;

    always #5 i_clk = ~i_clk;

    wb_commit_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_alloc_vld1  (i_alloc_vld1),
        .i_alloc_vld2  (i_alloc_vld2),
        .i_alloc_rd1   (i_alloc_rd1),
        .i_alloc_rd2   (i_alloc_rd2),
        .i_alloc_wren1 (i_alloc_wren1),
        .i_alloc_wren2 (i_alloc_wren2),
        .o_alloc_rdy   (o_alloc_rdy),
        .o_alloc_tag1  (o_alloc_tag1),
        .o_alloc_tag2  (o_alloc_tag2),
        .i_cmp_vld1    (i_cmp_vld1),
        .i_cmp_tag1    (i_cmp_tag1),
        .i_cmp_data1   (i_cmp_data1),
        .i_cmp_vld2    (i_cmp_vld2),
        .i_cmp_tag2    (i_cmp_tag2),
        .i_cmp_data2   (i_cmp_data2),
        .o_wb_rf_pkg   (o_wb_rf_pkg),
        .o_empty       (o_empty)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Regfile consumer: slot 2 is written last so it wins on equal addresses.
    logic [31:0] rf [32] = '{default: '0};
    always @(posedge i_clk) begin
        if (o_wb_rf_pkg.wren_instr1) rf[o_wb_rf_pkg.rd_addr_instr1] <= o_wb_rf_pkg.rd_data_instr1;
        if (o_wb_rf_pkg.wren_instr2) rf[o_wb_rf_pkg.rd_addr_instr2] <= o_wb_rf_pkg.rd_data_instr2;
    end

    typedef struct {
        logic             flush;
        logic             av1, av2;
        logic [4:0]       rd1, rd2;
        logic             we1, we2;
        logic             cv1;
        logic [TAG_W-1:0] ct1;
        logic [31:0]      cd1;
        logic             cv2;
        logic [TAG_W-1:0] ct2;
        logic [31:0]      cd2;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        w1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        w2;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic        empty;
        int          t1, t2;
        int          reg_idx;
        logic [31:0] reg_val;
    } vec_t;

    // Reference model: program-ordered queue of live instructions.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        logic             wren;
        logic             done;
        logic [31:0]      data;
    } mentry_t;

    mentry_t mq[$];
    int      m_tail = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t st_idle();
        stim_t s;
        s = '{flush: 1'b0, av1: 1'b0, av2: 1'b0, rd1: '0, rd2: '0, we1: 1'b0, we2: 1'b0,
              cv1: 1'b0, ct1: '0, cd1: '0, cv2: 1'b0, ct2: '0, cd2: '0};
        return s;
    endfunction

    function automatic stim_t st_alloc(bit v1, bit v2, int rd1, int rd2, bit we);
        stim_t s = st_idle();
        s.av1 = v1; s.av2 = v2; s.rd1 = 5'(rd1); s.rd2 = 5'(rd2); s.we1 = we; s.we2 = we;
        return s;
    endfunction

    function automatic stim_t st_cmp(bit v1, int t1, logic [31:0] d1, bit v2, int t2, logic [31:0] d2);
        stim_t s = st_idle();
        s.cv1 = v1; s.ct1 = TAG_W'(t1); s.cd1 = d1;
        s.cv2 = v2; s.ct2 = TAG_W'(t2); s.cd2 = d2;
        return s;
    endfunction

    function automatic vec_t mkv(stim_t s, bit w1, int a1, logic [31:0] d1, bit w2, int a2,
                                 logic [31:0] d2, bit empty, int t1, int t2, int ri, logic [31:0] rv);
        vec_t v;
        v.s = s; v.w1 = w1; v.a1 = 5'(a1); v.d1 = d1; v.w2 = w2; v.a2 = 5'(a2); v.d2 = d2;
        v.empty = empty; v.t1 = t1; v.t2 = t2; v.reg_idx = ri; v.reg_val = rv;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        i_flush = s.flush;
        i_alloc_vld1 = s.av1; i_alloc_vld2 = s.av2;
        i_alloc_rd1 = s.rd1;  i_alloc_rd2 = s.rd2;
        i_alloc_wren1 = s.we1; i_alloc_wren2 = s.we2;
        i_cmp_vld1 = s.cv1; i_cmp_tag1 = s.ct1; i_cmp_data1 = s.cd1;
        i_cmp_vld2 = s.cv2; i_cmp_tag2 = s.ct2; i_cmp_data2 = s.cd2;
    endtask

    // Called just after a rising edge; drives one cycle, steps the model, checks after the edge.
    task automatic apply_stimulus(input stim_t s, output logic [TAG_W-1:0] t1, output logic [TAG_W-1:0] t2);
        writeback_s exp_wb;
        bit         r1, r2, rdy_pre;
        drive(s);
        #1;
        t1 = o_alloc_tag1;
        t2 = o_alloc_tag2;
        check_output("model_tag1", 64'(t1), 64'(m_tail));
        check_output("model_tag2", 64'(t2), 64'((s.av2 && !s.av1) ? m_tail : (m_tail + 1) % DEPTH));

        exp_wb  = '0;
        r1      = (mq.size() >= 1) && mq[0].done;
        r2      = r1 && (mq.size() >= 2) && mq[1].done;
        rdy_pre = (DEPTH - mq.size()) >= 2;
        if (r1) begin
            exp_wb.rd_addr_instr1 = mq[0].rd;
            exp_wb.rd_data_instr1 = mq[0].data;
            exp_wb.wren_instr1    = mq[0].wren && (mq[0].rd != 0);
        end
        if (r2) begin
            exp_wb.rd_addr_instr2 = mq[1].rd;
            exp_wb.rd_data_instr2 = mq[1].data;
            exp_wb.wren_instr2    = mq[1].wren && (mq[1].rd != 0);
        end
        if (exp_wb.wren_instr2 && exp_wb.rd_addr_instr1 == exp_wb.rd_addr_instr2)
            exp_wb.wren_instr1 = 1'b0;

        if (s.flush) begin
            exp_wb = '0;
            mq.delete();
            m_tail = 0;
        end else begin
            foreach (mq[i]) begin
                if (s.cv1 && mq[i].tag == s.ct1) begin mq[i].done = 1'b1; mq[i].data = s.cd1; end
                if (s.cv2 && mq[i].tag == s.ct2) begin mq[i].done = 1'b1; mq[i].data = s.cd2; end
            end
            if (r2) void'(mq.pop_front());
            if (r1) void'(mq.pop_front());
            if (rdy_pre && s.av1) begin
                mq.push_back('{tag: TAG_W'(m_tail), rd: s.rd1, wren: s.we1, done: 1'b0, data: '0});
                m_tail = (m_tail + 1) % DEPTH;
            end
            if (rdy_pre && s.av2) begin
                mq.push_back('{tag: TAG_W'(m_tail), rd: s.rd2, wren: s.we2, done: 1'b0, data: '0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end

        @(posedge i_clk);
        #1;
        check_output("model_wren1", 64'(o_wb_rf_pkg.wren_instr1), 64'(exp_wb.wren_instr1));
        check_output("model_addr1", 64'(o_wb_rf_pkg.rd_addr_instr1), 64'(exp_wb.rd_addr_instr1));
        check_output("model_data1", 64'(o_wb_rf_pkg.rd_data_instr1), 64'(exp_wb.rd_data_instr1));
        check_output("model_wren2", 64'(o_wb_rf_pkg.wren_instr2), 64'(exp_wb.wren_instr2));
        check_output("model_addr2", 64'(o_wb_rf_pkg.rd_addr_instr2), 64'(exp_wb.rd_addr_instr2));
        check_output("model_data2", 64'(o_wb_rf_pkg.rd_data_instr2), 64'(exp_wb.rd_data_instr2));
        check_output("model_rdy", 64'(o_alloc_rdy), 64'((DEPTH - mq.size()) >= 2));
        check_output("model_empty", 64'(o_empty), 64'(mq.size() == 0));
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_wb"}, 64'(o_wb_rf_pkg == '0), 64'd1);
        check_output({tag, "_rdy"}, 64'(o_alloc_rdy), 64'd1);
        check_output({tag, "_empty"}, 64'(o_empty), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t             tbl[$];
        logic [TAG_W-1:0] t1, t2, t_before;
        stim_t            s;
        int               cand[$];
        int               k;
        bit               drained;

        repeat (2) @(posedge i_clk);
        #1;
        check_reset_state("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // In-order, out-of-order, same-rd hazard, x0 and compacted younger allocation.
        tbl.push_back(mkv(st_alloc(1, 1, 1, 2, 1),                            0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0));
        tbl.push_back(mkv(st_cmp(1, 0, 32'h12345678, 1, 1, 32'hABCD6789),      0, 0, 0, 0, 0, 0, 0, 2, 3, -1, 0));
        tbl.push_back(mkv(st_idle(), 1, 1, 32'h12345678, 1, 2, 32'hABCD6789,   1, 2, 3, -1, 0));
        tbl.push_back(mkv(st_idle(),                                          0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 32'h12345678));
        tbl.push_back(mkv(st_alloc(1, 1, 10, 11, 1),                          0, 0, 0, 0, 0, 0, 0, 2, 3, 2, 32'hABCD6789));
        tbl.push_back(mkv(st_cmp(1, 3, 32'h00001234, 0, 0, 0),                0, 0, 0, 0, 0, 0, 0, 4, 5, -1, 0));
        tbl.push_back(mkv(st_idle(),                                          0, 0, 0, 0, 0, 0, 0, 4, 5, -1, 0));
        tbl.push_back(mkv(st_cmp(1, 2, 32'h0000ABCD, 0, 0, 0),                0, 0, 0, 0, 0, 0, 0, 4, 5, -1, 0));
        tbl.push_back(mkv(st_idle(), 1, 10, 32'h0000ABCD, 1, 11, 32'h00001234, 1, 4, 5, -1, 0));
        tbl.push_back(mkv(st_alloc(1, 1, 1, 1, 1),                            0, 0, 0, 0, 0, 0, 0, 4, 5, 10, 32'h0000ABCD));
        tbl.push_back(mkv(st_cmp(1, 4, 32'h11223344, 1, 5, 32'hAABBCCDD),      0, 0, 0, 0, 0, 0, 0, 6, 7, 11, 32'h00001234));
        tbl.push_back(mkv(st_idle(), 0, 1, 32'h11223344, 1, 1, 32'hAABBCCDD,   1, 6, 7, -1, 0));
        tbl.push_back(mkv(st_alloc(1, 0, 0, 0, 1),                            0, 0, 0, 0, 0, 0, 0, 6, 7, 1, 32'hAABBCCDD));
        tbl.push_back(mkv(st_cmp(1, 6, 32'hFFFFFFFF, 0, 0, 0),                0, 0, 0, 0, 0, 0, 0, 7, 0, -1, 0));
        tbl.push_back(mkv(st_idle(), 0, 0, 32'hFFFFFFFF, 0, 0, 0,             1, 7, 0, -1, 0));
        tbl.push_back(mkv(st_alloc(0, 1, 0, 5, 1),                            0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 32'h0));
        tbl.push_back(mkv(st_cmp(0, 0, 0, 1, 7, 32'h00000055),                0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0));
        tbl.push_back(mkv(st_idle(), 1, 5, 32'h00000055, 0, 0, 0,             1, 0, 1, -1, 0));
        tbl.push_back(mkv(st_idle(),                                          0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 32'h00000055));

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].s, t1, t2);
            check_output("tbl_tag1", 64'(t1), 64'(tbl[i].t1));
            check_output("tbl_tag2", 64'(t2), 64'(tbl[i].t2));
            check_output("tbl_wren1", 64'(o_wb_rf_pkg.wren_instr1), 64'(tbl[i].w1));
            check_output("tbl_addr1", 64'(o_wb_rf_pkg.rd_addr_instr1), 64'(tbl[i].a1));
            check_output("tbl_data1", 64'(o_wb_rf_pkg.rd_data_instr1), 64'(tbl[i].d1));
            check_output("tbl_wren2", 64'(o_wb_rf_pkg.wren_instr2), 64'(tbl[i].w2));
            check_output("tbl_addr2", 64'(o_wb_rf_pkg.rd_addr_instr2), 64'(tbl[i].a2));
            check_output("tbl_data2", 64'(o_wb_rf_pkg.rd_data_instr2), 64'(tbl[i].d2));
            check_output("tbl_empty", 64'(o_empty), 64'(tbl[i].empty));
            if (tbl[i].reg_idx >= 0)
                check_output("tbl_regfile", 64'(rf[tbl[i].reg_idx]), 64'(tbl[i].reg_val));
        end

        // Fill to seven entries: ready drops, and a further request leaves the tail alone.
        for (int i = 0; i < 3; i++) apply_stimulus(st_alloc(1, 1, 8 + 2 * i, 9 + 2 * i, 1), t1, t2);
        apply_stimulus(st_alloc(1, 0, 20, 0, 1), t1, t2);
        check_output("full_rdy", 64'(o_alloc_rdy), 64'd0);
        apply_stimulus(st_alloc(1, 1, 21, 22, 1), t_before, t2);
        check_output("full_tag_before", 64'(t_before), 64'd7);
        apply_stimulus(st_idle(), t1, t2);
        check_output("full_tail_kept", 64'(t1), 64'd7);

        drained = 1'b0;
        for (int cyc = 0; cyc < 30 && !drained; cyc++) begin
            s = st_idle();
            cand.delete();
            foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
            if (cand.size() > 0) begin s.cv1 = 1'b1; s.ct1 = mq[cand[0]].tag; s.cd1 = 32'h100 + cyc; end
            if (cand.size() > 1) begin s.cv2 = 1'b1; s.ct2 = mq[cand[1]].tag; s.cd2 = 32'h200 + cyc; end
            apply_stimulus(s, t1, t2);
            drained = (mq.size() == 0);
        end
        check_output("drain_empty", 64'(o_empty), 64'd1);
        check_output("drain_rdy", 64'(o_alloc_rdy), 64'd1);

        // Flush with three live entries plus a same-cycle alloc and completion.
        apply_stimulus(st_alloc(1, 1, 3, 4, 1), t1, t2);
        check_output("wrap_tag1", 64'(t1), 64'd7);
        check_output("wrap_tag2", 64'(t2), 64'd0);
        apply_stimulus(st_alloc(1, 0, 6, 0, 1), t1, t2);
        s = st_alloc(1, 1, 12, 13, 1);
        s.flush = 1'b1; s.cv1 = 1'b1; s.ct1 = 3'd0; s.cd1 = 32'hDEADBEEF;
        apply_stimulus(s, t1, t2);
        check_output("flush_empty", 64'(o_empty), 64'd1);
        check_output("flush_rdy", 64'(o_alloc_rdy), 64'd1);
        apply_stimulus(st_idle(), t1, t2);
        check_output("flush_tail", 64'(t1), 64'd0);
        check_output("flush_nowren", 64'(o_wb_rf_pkg.wren_instr1 | o_wb_rf_pkg.wren_instr2), 64'd0);
        apply_stimulus(st_cmp(1, 7, 32'hCAFEF00D, 0, 0, 0), t1, t2);
        apply_stimulus(st_idle(), t1, t2);
        check_output("late_cmp_nowren", 64'(o_wb_rf_pkg.wren_instr1 | o_wb_rf_pkg.wren_instr2), 64'd0);
        check_output("late_cmp_empty", 64'(o_empty), 64'd1);

        // Asynchronous reset in the middle of traffic.
        apply_stimulus(st_alloc(1, 1, 7, 8, 1), t1, t2);
        apply_stimulus(st_cmp(1, 0, 32'h77777777, 0, 0, 0), t1, t2);
        drive(st_idle());
        i_rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        mq.delete();
        m_tail = 0;
        #2 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Random traffic against the queue model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            s = st_idle();
            s.flush = ($urandom_range(31) == 0);
            s.av1 = 1'($urandom); s.av2 = 1'($urandom);
            s.rd1 = 5'($urandom_range(3)); s.rd2 = 5'($urandom_range(3));
            s.we1 = ($urandom_range(3) != 0); s.we2 = ($urandom_range(3) != 0);
            cand.delete();
            foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(3) != 0) begin
                k = int'($urandom_range(cand.size() - 1));
                s.cv1 = 1'b1; s.ct1 = mq[cand[k]].tag; s.cd1 = $urandom;
                cand.delete(k);
            end
            if (cand.size() > 0 && $urandom_range(3) != 0) begin
                k = int'($urandom_range(cand.size() - 1));
                s.cv2 = 1'b1; s.ct2 = mq[cand[k]].tag; s.cd2 = $urandom;
            end
            apply_stimulus(s, t1, t2);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
- Dual-issue in-order commit buffer that produces the writeback package consumed by the regfile write ports.
- Scheduler allocates up to 2 entries per cycle in program order. Execution units complete results out of order by tag.
- The buffer retires up to 2 completed head entries per cycle, in order, as a registered writeback_s package.
- Sits between execute/complete and regfile. It is the writer side of the regfile writeback interface.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
TAG_W, $clog2(DEPTH), tag/pointer width

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_flush  in  1  discard all entries (pipeline flush)
i_alloc_vld1  in  1  allocate slot for older instruction
i_alloc_vld2  in  1  allocate slot for younger instruction
i_alloc_rd1  in  5  destination reg, instr1
i_alloc_rd2  in  5  destination reg, instr2
i_alloc_wren1  in  1  instr1 writes a register
i_alloc_wren2  in  1  instr2 writes a register
o_alloc_rdy  out  1  at least 2 free entries
o_alloc_tag1  out  TAG_W  tag given to instr1 this cycle
o_alloc_tag2  out  TAG_W  tag given to instr2 this cycle
i_cmp_vld1  in  1  completion port 1 valid
i_cmp_tag1  in  TAG_W  completion port 1 tag
i_cmp_data1  in  32  completion port 1 result
i_cmp_vld2  in  1  completion port 2 valid
i_cmp_tag2  in  TAG_W  completion port 2 tag
i_cmp_data2  in  32  completion port 2 result
o_wb_rf_pkg  out  writeback_s  rd_addr/rd_data/wren for instr1, instr2 to regfile
o_empty  out  1  count == 0

Behaviour:
- Reset (async, i_rst_n=0):
  - head = tail = count = 0; all entry valid/done = 0.
  - o_wb_rf_pkg all fields 0.
  - o_alloc_rdy = 1; o_empty = 1.
- Entry fields: valid, done, rd[4:0], wren, data[31:0].
- o_alloc_rdy = (DEPTH - count) >= 2, from registered count only (no same-cycle retire credit).
- Allocation, only when o_alloc_rdy=1; otherwise alloc requests are ignored:
  - o_alloc_tag1 = tail, o_alloc_tag2 = tail+1 (combinational).
  - vld1 only: write at tail, tail += 1.
  - vld1 and vld2: tail and tail+1, tail += 2.
  - vld2 only: instr2 takes tail (compacted), tail += 1; o_alloc_tag2 = tail in this case.
  - Pointers wrap modulo DEPTH.
- Completion:
  - On each valid cmp port, entry[tag].data <= data and done <= 1 at the edge.
  - Completion to an entry with valid=0 is ignored and flagged by assertion.
  - Both ports naming the same tag is illegal (assertion).
- Retire, evaluated on registered state:
  - r1 = entry[head].valid & done.
  - r2 = r1 & entry[head+1].valid & done.
  - Retired entries are cleared; head += r1 + r2.
  - An entry completed at edge N is retire-eligible in cycle N+1. Its writeback is on o_wb_rf_pkg after edge N+1, and the regfile writes it at edge N+2.
- Output register, loaded every cycle:
  - rd_addr_instr1/rd_data_instr1 from head; wren_instr1 = r1 & wren & (rd != 0).
  - Slot 2 from head+1 on the same rule with r2.
  - If r1 is 0, slot 2 is 0. The older entry always occupies slot 1.
  - Same-rd hazard: if both wren and rd1 == rd2, wren_instr1 is forced 0. Younger value wins regardless of regfile port priority.
  - Non-retiring cycle: all wren = 0, addr/data = 0.
- count_next = count + allocs - retires; simultaneous alloc and retire is legal.
- count never exceeds DEPTH (guaranteed by the rdy rule).
- Flush, synchronous, priority over alloc, completion and retire in the same cycle:
  - Clears valid/done, head = tail = count = 0.
  - o_wb_rf_pkg wren = 0 on the next edge.
- Reset mid-operation discards all entries immediately (async).

Decomposition:
- aqua_pkg:
  - reuses writeback_s.
  - adds commit_entry_s {valid, done, rd, wren, data}.
  - adds a localparam for the default DEPTH.
- Sub-module: wb_commit_ptr, the head/tail/count pointer and counter logic with wrap and the rdy computation.
- Entry array and output mux stay in the top.

Test Plan:
1. Reset, then check o_wb_rf_pkg = 0, o_alloc_rdy = 1, o_empty = 1.
2. In-order, ideal latency:
   - Stimulus: alloc rd=1 and rd=2, tags 0 and 1; next cycle complete tag0 = 32'h12345678 and tag1 = 32'hABCD6789.
   - Response: the next cycle shows both wren=1 with those values. Read-back through the regfile returns R1 = 32'h12345678, R2 = 32'hABCD6789.
3. Out-of-order completion:
   - Stimulus: alloc R10 then R11; complete tag1 = 32'h00001234 first.
   - Response: no wren while tag0 is pending. After tag0 = 32'h0000ABCD completes, both retire in one cycle in order.
4. Same-rd hazard and x0 suppression:
   - Hazard stimulus: alloc R1/R1 with data 32'h11223344 / 32'hAABBCCDD. Response: wren_instr1 = 0, and R1 reads 32'hAABBCCDD.
   - x0 stimulus: alloc rd=0 with data 32'hFFFFFFFF. Response: the entry retires with wren = 0, and R0 stays 0.
5. Full and wrap:
   - Allocate 8 entries (DEPTH=8) with no completions. o_alloc_rdy = 0 once count = 7; an extra alloc is ignored, tail unchanged.
   - Complete all entries. They retire 2 per cycle, pointers wrap, and count returns to 0.
6. Flush:
   - Stimulus: i_flush with 3 pending entries plus an alloc and a completion in the same cycle.
   - Response: count = 0, o_empty = 1, no wren afterwards, and a late completion to an old tag is ignored.
